uart_tx_param: RTL and testbench

Parametrised, buffered UART transmitter: next generation of the single-word UART TX, generalised in data width, bit period and stop-bit count, with a small input FIFO so the producer can queue frames while one is on the line. Sits between the byte-producing logic and the serial pin. Each queued word carries its own framing configuration.

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx_param.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the parametrised UART transmitter:
//   - FSM state encoding (enum for readability, plain 3-bit constants for the FSM)
//   - parity type encoding
//   - frame_len(): cycles a frame occupies the line, used by checkers/scoreboards
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Start + data + optional parity + one or two stop bits, in clk cycles.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned clks_per_bit,
                                              input logic        par_en,
                                              input logic        stop2);
        return (32'd2 + data_w + {31'd0, par_en} + {31'd0, stop2}) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous single-clock FIFO queueing words (data + framing config) ahead
// of the serializer. Read data is the current head (show-ahead), so the
// consumer samples rd_data in the same cycle it asserts rd_en.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   wr_en, wr_data  push (ignored when full)
//   rd_en, rd_data  pop (ignored when empty); rd_data is the head word
//   full, empty     occupancy flags
//   count           words stored, 0..DEPTH
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow; the
    // count (one bit wider than the pointers) tells full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Buffered, parametrised UART transmitter. Words are queued together with
// their own framing (parity enable/type, stop-bit count) and sent LSB first.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   DATA_VALID   producer offers {STOP2, PAR_TYP, PAR_EN, P_DATA}
//   DATA_READY   queue not full; write happens on DATA_VALID && DATA_READY
//   FIFO_COUNT   words waiting (frame on the line not included)
//   TX_OUT       serial line, idle high
//   Busy         a frame is on the line
// DATA_W legal 5..9, CLKS_PER_BIT >= 1, FIFO_DEPTH power of two >= 2.
module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          DATA_VALID,
    input  logic [DATA_W-1:0]             P_DATA,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    output logic                          DATA_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          TX_OUT,
    output logic                          Busy
);

    localparam int FW = DATA_W + 3;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);

    // FIFO word layout: {stop2, par_typ, par_en, data}
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    logic [DATA_W-1:0] head_data;
    logic              head_pen;
    logic              head_typ;
    logic              head_stop2;

    logic [2:0]        state;
    logic [CW-1:0]     clk_cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              cfg_pen;
    logic              cfg_stop2;

    logic              bit_done;
    logic              stop_done;

    assign fifo_wdata = {STOP2, PAR_TYP, PAR_EN, P_DATA};

    uart_tx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (DATA_VALID),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (FIFO_COUNT)
    );

    // Ready reflects the registered full flag, so a pop in a full cycle only
    // frees a slot from the next cycle on.
    assign DATA_READY = !fifo_full;

    assign head_data  = fifo_rdata[DATA_W-1:0];
    assign head_pen   = fifo_rdata[DATA_W];
    assign head_typ   = fifo_rdata[DATA_W+1];
    assign head_stop2 = fifo_rdata[DATA_W+2];

    assign bit_done  = (clk_cnt == CLK_LAST);
    // Last cycle of the last stop bit: bit_cnt counts stop bits 0 (and 1).
    assign stop_done = (state == ST_STOP) && bit_done &&
                       (bit_cnt == {3'b000, cfg_stop2});
    // Popping at stop_done chains frames with no idle cycle in between.
    assign pop = !fifo_empty && ((state == ST_IDLE) || stop_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_stop2 <= 1'b0;
        end else begin
            // Parity is computed from the whole word at load time, since the
            // shift register is consumed while the data bits go out.
            if (pop) begin
                shreg     <= head_data;
                par_bit   <= (^head_data) ^ (head_typ == PAR_ODD);
                cfg_pen   <= head_pen;
                cfg_stop2 <= head_stop2;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (bit_done) begin
                        state   <= ST_DATA;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        shreg   <= shreg >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            state   <= cfg_pen ? ST_PARITY : ST_STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (bit_done) begin
                        state   <= ST_STOP;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (stop_done) begin
                            state   <= fifo_empty ? ST_IDLE : ST_START;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        TX_OUT = 1'b1;
        case (state)
            ST_START:  TX_OUT = 1'b0;
            ST_DATA:   TX_OUT = shreg[0];
            ST_PARITY: TX_OUT = par_bit;
            default:   TX_OUT = 1'b1;
        endcase
    end

    assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Directed bench for uart_tx_param: a default instance (8 bits, 16 clk/bit)
// and a narrow fast instance (7 bits, 1 clk/bit). The line of each instance
// is logged every cycle it is busy; tests slice that log into frames and
// compare with hand-built frame vectors ({stop, parity, data, start}).
module tb_uart_tx_param;
    import uart_tx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default instance
    logic       rst0 = 1'b1;
    logic       dv0 = 1'b0, pen0 = 1'b0, typ0 = 1'b0, s20 = 1'b0;
    logic [7:0] pd0 = '0;
    logic       rdy0, tx0, busy0;
    logic [2:0] cnt0;

    // narrow/fast instance
    logic       rst1 = 1'b1;
    logic       dv1 = 1'b0, pen1 = 1'b0, typ1 = 1'b0, s21 = 1'b0;
    logic [6:0] pd1 = '0;
    logic       rdy1, tx1, busy1;
    logic [2:0] cnt1;

    uart_tx_param dut0 (
        .clk(clk), .reset(rst0), .DATA_VALID(dv0), .P_DATA(pd0),
        .PAR_EN(pen0), .PAR_TYP(typ0), .STOP2(s20),
        .DATA_READY(rdy0), .FIFO_COUNT(cnt0), .TX_OUT(tx0), .Busy(busy0)
    );

    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(rst1), .DATA_VALID(dv1), .P_DATA(pd1),
        .PAR_EN(pen1), .PAR_TYP(typ1), .STOP2(s21),
        .DATA_READY(rdy1), .FIFO_COUNT(cnt1), .TX_OUT(tx1), .Busy(busy1)
    );

    // line log while busy, plus count of Busy falling edges
    logic q0[$];
    logic q1[$];
    int   falls0 = 0, falls1 = 0;
    logic bd0 = 1'b0, bd1 = 1'b0;

    always @(negedge clk) begin
        if (busy0) q0.push_back(tx0);
        if (bd0 && !busy0) falls0++;
        bd0 = busy0;
        if (busy1) q1.push_back(tx1);
        if (bd1 && !busy1) falls1++;
        bd1 = busy1;
    end

    // mid-bit samples of a frame starting at log index start
    function automatic logic [15:0] grab0(input int start, input int nbits);
        logic [15:0] v;
        v = '0;
        for (int b = 0; b < nbits; b++) begin
            if (start + b*16 + 8 < q0.size()) v[b] = q0[start + b*16 + 8];
            else v[b] = 1'bx;
        end
        return v;
    endfunction

    function automatic logic [15:0] grab1(input int start, input int nbits);
        logic [15:0] v;
        v = '0;
        for (int b = 0; b < nbits; b++) begin
            if (start + b < q1.size()) v[b] = q1[start + b];
            else v[b] = 1'bx;
        end
        return v;
    endfunction

    task automatic put0(input logic [7:0] d, input logic pe, input logic ty, input logic s2);
        dv0 = 1'b1; pd0 = d; pen0 = pe; typ0 = ty; s20 = s2;
        @(negedge clk);
        dv0 = 1'b0; pen0 = ~pe; typ0 = ~ty; s20 = ~s2;
    endtask

    task automatic put1(input logic [6:0] d, input logic pe, input logic ty, input logic s2);
        dv1 = 1'b1; pd1 = d; pen1 = pe; typ1 = ty; s21 = s2;
        @(negedge clk);
        dv1 = 1'b0; pen1 = ~pe; typ1 = ~ty; s21 = ~s2;
    endtask

    // wait for Busy to fall past reference count f; ok=0 on timeout
    task automatic wait_done0(input int f, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (falls0 > f) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done1(input int f, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (falls1 > f) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL reset_tx0: got %b want 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_ready0: got %b want 1", rdy0); end
        checks++; if (cnt0 !== 3'd0)  begin errors++; $display("FAIL reset_count0: got %0d want 0", cnt0); end
        checks++; if (tx1 !== 1'b1)   begin errors++; $display("FAIL reset_tx1: got %b want 1", tx1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    endtask

    task automatic test_basic_frame();
        int idx, f, len;
        bit ok;
        logic [15:0] got;
        idx = q0.size(); f = falls0;
        put0(8'hA5, 1'b1, PAR_EVEN, 1'b0);
        checks++; if (cnt0 !== 3'd1)  begin errors++; $display("FAIL basic_count_after_write: got %0d want 1", cnt0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_after_write: got %b want 0", busy0); end
        @(negedge clk);
        checks++; if (cnt0 !== 3'd0)  begin errors++; $display("FAIL basic_count_after_pop: got %0d want 0", cnt0); end
        checks++; if (tx0 !== 1'b0)   begin errors++; $display("FAIL basic_start_bit: got %b want 0", tx0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_pop: got %b want 1", busy0); end
        wait_done0(f, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy never fell"); end
        len = q0.size() - idx;
        checks++; if (len != 176) begin errors++; $display("FAIL basic_busy_len: got %0d want 176", len); end
        checks++; if (len != int'(frame_len(8, 16, 1'b1, 1'b0))) begin errors++; $display("FAIL basic_frame_len_fn: got %0d want %0d", len, frame_len(8, 16, 1'b1, 1'b0)); end
        got = grab0(idx, 11);
        checks++; if (got !== {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}) begin errors++; $display("FAIL basic_bits: got %b want %b", got, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}); end
    endtask

    task automatic test_narrow_fast();
        int idx, f, len;
        bit ok;
        logic [15:0] got;
        idx = q1.size(); f = falls1;
        put1(7'h55, 1'b1, PAR_ODD, 1'b1);
        wait_done1(f, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL narrow_timeout: busy never fell"); end
        len = q1.size() - idx;
        checks++; if (len != 11) begin errors++; $display("FAIL narrow_len: got %0d want 11", len); end
        got = grab1(idx, 11);
        checks++; if (got !== {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}) begin errors++; $display("FAIL narrow_bits: got %b want %b", got, {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}); end
    endtask

    task automatic test_back_to_back();
        int idx, f, len;
        bit ok;
        logic [15:0] got;
        logic [7:0] d [5];
        d = '{8'h11, 8'h22, 8'h3C, 8'h80, 8'hFE};
        idx = q0.size(); f = falls0;
        for (int k = 0; k < 5; k++) put0(d[k], 1'b0, PAR_EVEN, 1'b0);
        checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL b2b_full_count: got %0d want 4", cnt0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_not_ready: got %b want 0", rdy0); end
        repeat (100) @(negedge clk);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_midframe: got %b want 0", rdy0); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || busy0 !== 1'b1 || cnt0 !== 3'd3) begin errors++; $display("FAIL b2b_ready_rise: ready=%b busy=%b count=%0d want 1 1 3", rdy0, busy0, cnt0); end
        wait_done0(f, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: busy never fell"); end
        len = q0.size() - idx;
        checks++; if (len != 800) begin errors++; $display("FAIL b2b_len: got %0d want 800", len); end
        checks++; if (falls0 != f + 1) begin errors++; $display("FAIL b2b_gap: busy falls %0d want 1", falls0 - f); end
        for (int k = 0; k < 5; k++) begin
            got = grab0(idx + k*160, 10);
            checks++; if (got !== {6'b0, 1'b1, d[k], 1'b0}) begin errors++; $display("FAIL b2b_frame%0d: got %b want %b", k, got, {6'b0, 1'b1, d[k], 1'b0}); end
        end
    endtask

    task automatic test_parity_toggle();
        int idx, f, len;
        bit ok;
        logic [15:0] got;
        idx = q0.size(); f = falls0;
        put0(8'h0F, 1'b1, PAR_EVEN, 1'b0);
        put0(8'h33, 1'b0, PAR_EVEN, 1'b0);
        put0(8'h07, 1'b1, PAR_EVEN, 1'b0);
        wait_done0(f, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL partog_timeout: busy never fell"); end
        len = q0.size() - idx;
        checks++; if (len != 512) begin errors++; $display("FAIL partog_len: got %0d want 512", len); end
        got = grab0(idx, 11);
        checks++; if (got !== {5'b0, 1'b1, 1'b0, 8'h0F, 1'b0}) begin errors++; $display("FAIL partog_f0: got %b want %b", got, {5'b0, 1'b1, 1'b0, 8'h0F, 1'b0}); end
        got = grab0(idx + 176, 10);
        checks++; if (got !== {6'b0, 1'b1, 8'h33, 1'b0}) begin errors++; $display("FAIL partog_f1: got %b want %b", got, {6'b0, 1'b1, 8'h33, 1'b0}); end
        got = grab0(idx + 336, 11);
        checks++; if (got !== {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}) begin errors++; $display("FAIL partog_f2: got %b want %b", got, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}); end
    endtask

    task automatic test_reset_midframe();
        int idx;
        put0(8'hC3, 1'b1, PAR_EVEN, 1'b0);
        put0(8'h3C, 1'b1, PAR_EVEN, 1'b0);
        repeat (38) @(negedge clk);   // second data bit
        checks++; if (busy0 !== 1'b1 || cnt0 !== 3'd1) begin errors++; $display("FAIL rstmid_pre: busy=%b count=%0d want 1 1", busy0, cnt0); end
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
        checks++; if (cnt0 !== 3'd0)  begin errors++; $display("FAIL rstmid_count: got %0d want 0", cnt0); end
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: got %b want 1", rdy0); end
        idx = q0.size();
        repeat (400) @(negedge clk);
        checks++; if (q0.size() != idx) begin errors++; $display("FAIL rstmid_no_frames: got %0d busy cycles want 0", q0.size() - idx); end
    endtask

    task automatic test_write_with_pop();
        int idx, f, len;
        bit ok;
        logic [15:0] got;
        logic [6:0] d [4];
        d = '{7'h01, 7'h12, 7'h23, 7'h34};
        idx = q1.size(); f = falls1;
        put1(d[0], 1'b0, PAR_EVEN, 1'b0);   // edge N
        put1(d[1], 1'b0, PAR_EVEN, 1'b0);   // edge N+1, pops d[0]
        put1(d[2], 1'b0, PAR_EVEN, 1'b0);   // edge N+2
        repeat (7) @(negedge clk);          // edges N+3..N+9
        checks++; if (cnt1 !== 3'd2) begin errors++; $display("FAIL wrpop_before: got %0d want 2", cnt1); end
        put1(d[3], 1'b0, PAR_EVEN, 1'b0);   // edge N+10, pops d[1]
        checks++; if (cnt1 !== 3'd2) begin errors++; $display("FAIL wrpop_count: got %0d want 2", cnt1); end
        checks++; if (busy1 !== 1'b1 || tx1 !== 1'b0) begin errors++; $display("FAIL wrpop_next_start: busy=%b tx=%b want 1 0", busy1, tx1); end
        wait_done1(f, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrpop_timeout: busy never fell"); end
        len = q1.size() - idx;
        checks++; if (len != 36) begin errors++; $display("FAIL wrpop_len: got %0d want 36", len); end
        for (int k = 0; k < 4; k++) begin
            got = grab1(idx + k*9, 9);
            checks++; if (got !== {7'b0, 1'b1, d[k], 1'b0}) begin errors++; $display("FAIL wrpop_frame%0d: got %b want %b", k, got, {7'b0, 1'b1, d[k], 1'b0}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_narrow_fast();
        test_back_to_back();
        test_parity_toggle();
        test_reset_midframe();
        test_write_with_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
